// File: rtl/stage_if_pkg.sv
// Shared constants and types for the instruction-fetch stage and its IF/ID register.
package stage_if_pkg;

  localparam logic        RESET_ENABLE  = 1'b0;
  localparam logic        RESET_DISABLE = 1'b1;
  localparam logic        STALL_ENABLE  = 1'b1;
  localparam logic        STALL_DISABLE = 1'b0;
  localparam logic [31:0] INST_NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/stage_if_reg_if_id.sv
// IF/ID pipeline latch: clear to NOP/0, load a fetched word and its address, or hold.
module reg_if_id
  import stage_if_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] next_instruction,
  input  logic [31:0] next_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc
);

  logic [31:0] instruction_reg;
  logic [31:0] pc_reg;

  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE || clear) begin
      instruction_reg <= INST_NOP;
      pc_reg          <= 32'h0;
    end else if (load) begin
      instruction_reg <= next_instruction;
      pc_reg          <= next_pc;
    end
  end

  assign instruction = instruction_reg;
  assign pc          = pc_reg;

endmodule

// File: rtl/stage_if.sv
// Instruction fetch: PC register, ROM drive, redirect/stall handling and the IF/ID latch.
// The word fetched in the same cycle as a redirect is kept as the delay slot.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        pc_write_enable,
  input  logic [31:0] pc_write_data,
  output logic        rom_read_enable,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] fetch_count
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] count_reg, count_next;
  logic        if_load;
  logic        if_clear;

  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      count_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    count_next = count_reg;
    if_load    = 1'b0;
    if_clear   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        state_next = S_RUN;
        if_clear   = 1'b1;
      end
      S_RUN: begin
        // A stall freezes everything, including a pending redirect; stage_id re-presents it.
        if (stall != STALL_ENABLE) begin
          if_load    = 1'b1;
          count_next = count_reg + 32'd1;
          pc_next    = pc_write_enable ? pc_write_data : pc_reg + PC_STEP;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign rom_read_enable = (state_reg == S_RUN);
  assign rom_address     = pc_reg;
  assign fetch_count     = count_reg;

  reg_if_id u_reg_if_id (
    .clock            (clock),
    .reset            (reset),
    .load             (if_load),
    .clear            (if_clear),
    .next_instruction (rom_data),
    .next_pc          (pc_reg),
    .instruction      (instruction_o),
    .pc               (pc_o)
  );

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: per-cycle model comparison plus directed literal checks.
module tb_stage_if;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        pc_write_enable;
  logic [31:0] pc_write_data;
  logic        rom_read_enable;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    if (addr == 32'h0000_0100) return 32'h3401_0005;
    return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign rom_data = rom_word(rom_address);

  stage_if #(.RESET_PC(RPC)) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .pc_write_enable (pc_write_enable),
    .pc_write_data   (pc_write_data),
    .rom_read_enable (rom_read_enable),
    .rom_address     (rom_address),
    .rom_data        (rom_data),
    .instruction_o   (instruction_o),
    .pc_o            (pc_o),
    .fetch_count     (fetch_count)
  );

  // Behavioural model: a started flag, the PC, the last accepted word and a count.
  bit          m_valid = 1'b0;
  bit          m_run;
  logic [31:0] m_pc, m_instr, m_addr, m_cnt;

  always @(posedge clock) begin
    if (reset === 1'b0) begin
      m_valid = 1'b1;
      m_run   = 1'b0;
      m_pc    = RPC;
      m_instr = 32'h0;
      m_addr  = 32'h0;
      m_cnt   = 32'h0;
    end else if (m_valid) begin
      if (!m_run) begin
        m_run   = 1'b1;
        m_instr = 32'h0;
        m_addr  = 32'h0;
      end else if (!stall) begin
        m_instr = rom_word(m_pc);
        m_addr  = m_pc;
        m_cnt   = m_cnt + 1;
        m_pc    = pc_write_enable ? pc_write_data : m_pc + 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (m_valid) begin
      chk("model rom_read_enable", {31'h0, rom_read_enable}, {31'h0, m_run});
      chk("model rom_address", rom_address, m_pc);
      chk("model instruction_o", instruction_o, m_instr);
      chk("model pc_o", pc_o, m_addr);
      chk("model fetch_count", fetch_count, m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; pc_write_enable = 1'b0; pc_write_data = 32'h0;
    cyc(); cyc();
    $display("reset held: rom_address=%08h fetch_count=%0d", rom_address, fetch_count);
    chk("reset instruction_o", instruction_o, 32'h0);
    chk("reset fetch_count", fetch_count, 32'h0);
    chk("reset rom_read_enable", {31'h0, rom_read_enable}, 32'h0);
    chk("reset rom_address", rom_address, 32'h100);

    reset = 1'b1;
    cyc();
    $display("edge1: ren=%0d rom_address=%08h", rom_read_enable, rom_address);
    chk("first edge rom_read_enable", {31'h0, rom_read_enable}, 32'h1);
    chk("first edge rom_address", rom_address, 32'h100);
    cyc();
    $display("edge2: instr=%08h pc_o=%08h", instruction_o, pc_o);
    chk("first word instruction_o", instruction_o, 32'h3401_0005);
    chk("first word pc_o", pc_o, 32'h100);
    chk("first word rom_address", rom_address, 32'h104);
    chk("first word fetch_count", fetch_count, 32'd1);
    cyc();
    chk("seq rom_address", rom_address, 32'h108);

    pc_write_enable = 1'b1; pc_write_data = 32'h200;
    cyc();
    $display("redirect: instr=%08h rom_address=%08h", instruction_o, rom_address);
    pc_write_enable = 1'b0;
    chk("delay slot instruction_o", instruction_o, rom_word(32'h108));
    chk("redirect rom_address", rom_address, 32'h200);
    cyc();
    chk("target instruction_o", instruction_o, rom_word(32'h200));
    chk("after target fetch_count", fetch_count, 32'd4);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      $display("stall %0d: rom_address=%08h count=%0d", i, rom_address, fetch_count);
      chk("stall rom_address", rom_address, 32'h204);
      chk("stall instruction_o", instruction_o, rom_word(32'h200));
      chk("stall fetch_count", fetch_count, 32'd4);
    end
    stall = 1'b0;
    cyc();
    chk("resume pc_o", pc_o, 32'h204);
    chk("resume rom_address", rom_address, 32'h208);

    stall = 1'b1; pc_write_enable = 1'b1; pc_write_data = 32'h300;
    cyc();
    $display("stall+redirect: rom_address=%08h", rom_address);
    chk("stall wins rom_address", rom_address, 32'h208);
    stall = 1'b0;
    cyc();
    chk("redirect after stall rom_address", rom_address, 32'h300);
    chk("redirect after stall fetch_count", fetch_count, 32'd6);

    pc_write_data = 32'hFFFF_FFFC;
    cyc();
    pc_write_enable = 1'b0;
    cyc();
    $display("wrap: rom_address=%08h pc_o=%08h", rom_address, pc_o);
    chk("wrap rom_address", rom_address, 32'h0);
    chk("wrap pc_o", pc_o, 32'hFFFF_FFFC);

    pc_write_enable = 1'b1; pc_write_data = 32'h0000_0123;
    cyc();
    pc_write_enable = 1'b0;
    cyc();
    chk("unaligned rom_address", rom_address, 32'h127);
    chk("unaligned fetch_count", fetch_count, 32'd10);

    stall = 1'b1; reset = 1'b0;
    cyc();
    $display("reset mid-stall: instr=%08h ren=%0d", instruction_o, rom_read_enable);
    chk("mid reset instruction_o", instruction_o, 32'h0);
    chk("mid reset pc_o", pc_o, 32'h0);
    chk("mid reset fetch_count", fetch_count, 32'h0);
    chk("mid reset rom_read_enable", {31'h0, rom_read_enable}, 32'h0);
    chk("mid reset rom_address", rom_address, 32'h100);

    reset = 1'b1; stall = 1'b0;
    cyc(); cyc();
    chk("restart instruction_o", instruction_o, 32'h3401_0005);
    cyc();
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage plus the IF/ID pipeline register. Holds the program counter, drives the instruction ROM, and latches the fetched word and its address for `stage_id`. Acts on `stage_id`'s `pc_write_enable`/`pc_write_data` redirect and on the pipeline stall. Uses MIPS delay-slot semantics: the instruction fetched alongside a taken jump or branch is always kept.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.

Ports:
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; `RESET_ENABLE` = 1'b0.
- `stall` in 1: hold request (`STALL_ENABLE`), from `stage_id` `stall_request` via the stall path.
- `pc_write_enable` in 1: redirect request from `stage_id`.
- `pc_write_data` in 32: redirect target from `stage_id`.
- `rom_read_enable` out 1: ROM read strobe.
- `rom_address` out 32: equals current PC.
- `rom_data` in 32: ROM word at `rom_address`, combinational read, same cycle.
- `instruction_o` out 32: IF/ID instruction, to `stage_id` `instruction_i`.
- `pc_o` out 32: IF/ID address, to `stage_id` `pc_read_data`.
- `fetch_count` out 32: number of words accepted into IF/ID since reset.

## Operation
State machine with two states, `S_IDLE` and `S_RUN`.

Reset (`reset`=0 at an edge):
- state ← `S_IDLE`; pc ← `RESET_PC`.
- `instruction_o`, `pc_o`, `fetch_count` ← 0.
- `rom_read_enable` = 0 (decoded from state).

`S_IDLE`:
- ROM is disabled; IF/ID loads the NOP 32'h0 and `pc_o` = 0.
- pc holds. Next state is `S_RUN` unconditionally; `stall` and redirect are ignored.

`S_RUN`:
- `rom_read_enable` = 1.
- Priority 1, `stall`=1:
  - pc, IF/ID and `fetch_count` all hold.
  - `pc_write_enable` is ignored. `stage_id` re-presents the redirect after the stall clears, because its inputs are held.
- Priority 2, `pc_write_enable`=1:
  - IF/ID ← {`rom_data`, pc}. This word is the delay slot.
  - pc ← `pc_write_data`.
  - `fetch_count` += 1.
- Otherwise:
  - IF/ID ← {`rom_data`, pc}.
  - pc ← pc + 4.
  - `fetch_count` += 1.

Width and arithmetic rules:
- pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- `fetch_count` wraps modulo 2^32.
- `pc_write_data` is taken as-is, with no alignment check.

## Timing
- Fetch latency: 1 cycle. A word read at pc in cycle N appears on `instruction_o` in cycle N+1.
- Redirect: when `pc_write_enable` is seen at edge N, `rom_address` equals the target in cycle N+1, and the target word reaches `instruction_o` in cycle N+2.
- After reset is released, the first edge moves the state `S_IDLE`→`S_RUN`. The second edge presents `rom[RESET_PC]` on `instruction_o`.
- Reset asserted mid-run: takes effect at the next edge regardless of `stall` or redirect. All outputs return to their reset values.
- `stall` and `pc_write_enable` both high: stall wins; nothing changes.
- `rom_address` changes only at edges, since it is a registered pc.

## Structure
- Shared `defines.v` gains `RESET_ENABLE`/`RESET_DISABLE` (1'b0/1'b1) and `STALL_ENABLE`/`STALL_DISABLE`, if not already present.
- Add `INST_NOP` (32'h0) and `PC_STEP` (32'd4) to `defines.v`.
- Sub-module: `reg_if_id`, the IF/ID latch with load/hold/clear.
- pc, the FSM and `fetch_count` stay in `stage_if`.

## Test plan
- Reset release, `RESET_PC`=32'h100, rom[100]=32'h3401_0005, no stall:
  - cycle 1: `rom_read_enable`=1, `rom_address`=32'h100.
  - cycle 2: `instruction_o`=32'h3401_0005, `pc_o`=32'h100, `rom_address`=32'h104, `fetch_count`=1.
- Redirect: `pc_write_enable`=1, `pc_write_data`=32'h200 while pc=32'h108 →
  - next cycle: `instruction_o`=rom[108] (delay slot), `rom_address`=32'h200.
  - the cycle after: `instruction_o`=rom[200].
- Stall: `stall`=1 for 3 cycles at pc=32'h10C → `rom_address`, `instruction_o`, `pc_o` and `fetch_count` are unchanged for 3 cycles, then resume with pc 32'h110.
- Stall plus redirect: `stall`=1 and `pc_write_enable`=1 (target 32'h300) for 1 cycle, then redirect alone →
  - pc is unchanged in the first cycle.
  - pc = 32'h300 after the second cycle.
- Wrap: pc=32'hFFFF_FFFC, no stall → next `rom_address`=32'h0.
- Reset mid-stall: `reset`=0 while `stall`=1 → next cycle: `instruction_o`=0, `pc_o`=0, `fetch_count`=0, `rom_read_enable`=0, `rom_address`=`RESET_PC`.
